// File: rtl/dep_scoreboard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : dep_scoreboard_pkg                                          |
// | Brief  : Shared operand-select encodings and defaults for the        |
// |          register dependency scoreboard.                             |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package dep_scoreboard_pkg;

  // Width of one per-source operand override select
  localparam int c_op_sel_size = 2;

  // Largest issue-to-writeback latency supported by the core
  localparam int c_dep_max_lat = 7;

  // Operand source override: register file, EXEC forward bus or WB bus
  typedef enum logic [c_op_sel_size-1:0] {
    OVERRIDE_NONE = 2'd0,
    OVERRIDE_EXEC = 2'd1,
    OVERRIDE_WB   = 2'd2
  } op_sel_e;

endpackage
`default_nettype wire

// File: rtl/dep_reg_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : dep_reg_counter                                             |
// | Brief  : Remaining-latency counter for one architectural register.   |
// |          Load on issue, count down to commit, clear on flush.        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module dep_reg_counter #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt,
  output logic             busy
);

  logic [LAT_W-1:0] r_cnt;
  logic             r_busy;
  logic [LAT_W-1:0] w_next;

  // Next count: flush drops everything (a cnt==1 entry commits anyway),
  // a new producer overrides the decrement, otherwise count down to idle
  always_comb begin
    w_next = r_cnt;
    if (flush) begin
      w_next = '0;
    end else if (load) begin
      w_next = load_val;
    end else if (r_cnt != '0) begin
      w_next = r_cnt - LAT_W'(1);
    end
  end

  // Counter and its busy flag are both flops so busy_vec is glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else begin
      r_cnt  <= w_next;
      r_busy <= (w_next != '0);
    end
  end

  assign cnt  = r_cnt;
  assign busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/dep_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : dep_scoreboard                                              |
// | Brief  : Per-register dependency scoreboard for the issue stage.     |
// |          RAW/WAW stall detection and per-source forward select.      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module dep_scoreboard
  import dep_scoreboard_pkg::*;
#(
  parameter int NUM_REGS   = 8,
  parameter int REG_ADDR_W = 3,
  parameter int NUM_SRC    = 2,
  parameter int MAX_LAT    = c_dep_max_lat,
  parameter int LAT_W      = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            issue_valid,
  input  logic [NUM_SRC-1:0]              issue_src_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]   issue_src,
  input  logic                            issue_dst_valid,
  input  logic [REG_ADDR_W-1:0]           issue_dst,
  input  logic [LAT_W-1:0]                issue_lat,
  input  logic                            flush,
  output logic                            issue_ready,
  output logic [NUM_SRC*c_op_sel_size-1:0] fwd_sel,
  output logic [NUM_REGS-1:0]             busy_vec,
  output logic [15:0]                     stall_cnt
);

  logic [LAT_W-1:0]   w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_SRC-1:0]  w_raw;
  logic                w_waw;
  logic                w_accept;
  logic [LAT_W-1:0]    w_eff_lat;
  logic [15:0]         r_stall_cnt;

  // A zero latency is illegal; treat it as a single-cycle producer
  assign w_eff_lat = (issue_lat == '0) ? LAT_W'(1) : issue_lat;

  // Flush cycles never record the presented instruction
  assign w_accept = issue_valid & issue_ready & ~flush;

  generate
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      logic w_load;
      assign w_load = w_accept & issue_dst_valid &
                      (issue_dst == REG_ADDR_W'(r));
      dep_reg_counter #(
        .LAT_W (LAT_W)
      ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .load     (w_load),
        .load_val (w_eff_lat),
        .cnt      (w_cnt[r]),
        .busy     (w_busy[r])
      );
    end
  endgenerate

  generate
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      logic [LAT_W-1:0] w_src_cnt;
      op_sel_e          w_sel;
      // Sources see pre-update state, so a self-dependent op reads the old entry
      assign w_src_cnt = w_cnt[issue_src[k*REG_ADDR_W +: REG_ADDR_W]];
      assign w_raw[k]  = issue_src_valid[k] & (w_src_cnt > LAT_W'(2));
      assign w_sel     = !issue_src_valid[k]        ? OVERRIDE_NONE :
                         (w_src_cnt == LAT_W'(1))   ? OVERRIDE_WB   :
                         (w_src_cnt == LAT_W'(2))   ? OVERRIDE_EXEC :
                                                      OVERRIDE_NONE;
      assign fwd_sel[k*c_op_sel_size +: c_op_sel_size] =
          issue_valid ? w_sel : OVERRIDE_NONE;
    end
  endgenerate

  // New writer must finish strictly after the pending one to keep WB ordered
  assign w_waw = issue_dst_valid & (w_cnt[issue_dst] >= w_eff_lat);

  assign issue_ready = ~((|w_raw) | w_waw);

  // Saturating count of cycles where a valid instruction was held back
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (issue_valid && !issue_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  // Flag illegal producer latencies presented for issue
  always_ff @(posedge clk) begin
    if (!rst && issue_valid && issue_dst_valid) begin
      assert ((issue_lat != '0) && (issue_lat <= LAT_W'(MAX_LAT)));
    end
  end

  assign busy_vec  = w_busy;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
